// File: rtl/fpro_timer_pkg.sv
// Shared constants for the FPro timer core: register word indices, CTRL/STATUS
// bit positions, default counter width and the CTRL read-back formatter.
package fpro_timer_pkg;

    localparam int CNT_W_DEF = 48;

    localparam logic [4:0] REG_CNT_LO = 5'd0;
    localparam logic [4:0] REG_CNT_HI = 5'd1;
    localparam logic [4:0] REG_CTRL   = 5'd2;
    localparam logic [4:0] REG_CMP_LO = 5'd3;
    localparam logic [4:0] REG_CMP_HI = 5'd4;
    localparam logic [4:0] REG_STATUS = 5'd5;

    localparam int CTRL_GO       = 0;
    localparam int CTRL_CLEAR    = 1;
    localparam int CTRL_PERIODIC = 2;
    localparam int CTRL_IE       = 3;

    localparam int STATUS_EXPIRED = 0;

    // clear is a write-only pulse, so its position always reads back as 0
    function automatic logic [31:0] ctrl_word(input logic go, input logic periodic, input logic ie);
        logic [31:0] w;
        w = 32'd0;
        w[CTRL_GO]       = go;
        w[CTRL_PERIODIC] = periodic;
        w[CTRL_IE]       = ie;
        return w;
    endfunction

endpackage

// File: rtl/fpro_timer_if.sv
// FPro MMIO slot bus between the slot decoder (master) and the timer core (slave).
interface fpro_timer_if;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (output cs, output read, output write, output addr, output wr_data, input rd_data);
    modport slave  (input cs, input read, input write, input addr, input wr_data, output rd_data);
endinterface

// File: rtl/fpro_timer_core.sv
// FPro memory-mapped timer: free-running/one-shot/periodic counter with a
// compare match, sticky expired flag (W1C), level interrupt and CNT_HI shadow.
module fpro_timer_core
    import fpro_timer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    fpro_timer_if.slave  bus,
    output logic         irq
);

    localparam int HI_W = CNT_W - 32;

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cmp_r;
    logic [HI_W-1:0]  shadow_r;
    logic             go_r;
    logic             periodic_r;
    logic             ie_r;
    logic             expired_r;

    logic             wr_s;
    logic             ctrl_wr_s;
    logic             clear_s;
    logic             w1c_s;
    logic             rd_lo_s;
    logic             hit_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic [31:0]      rd_mux_s;

    // Bus decode, compare match and next counter value
    always_comb begin
        wr_s      = bus.cs & bus.write;
        ctrl_wr_s = wr_s & (bus.addr == REG_CTRL);
        clear_s   = ctrl_wr_s & bus.wr_data[CTRL_CLEAR];
        w1c_s     = wr_s & (bus.addr == REG_STATUS) & bus.wr_data[STATUS_EXPIRED];
        rd_lo_s   = bus.cs & bus.read & (bus.addr == REG_CNT_LO);
        hit_s     = go_r & (cmp_r != {CNT_W{1'b0}}) & (cnt_r == cmp_r);
        // clear beats a periodic reload, which beats a one-shot hold / increment
        if (clear_s) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else if (hit_s) begin
            cnt_next_s = periodic_r ? {CNT_W{1'b0}} : cnt_r;
        end else if (go_r) begin
            cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Counter, control bits, expired flag and high-word shadow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r      <= {CNT_W{1'b0}};
            shadow_r   <= {HI_W{1'b0}};
            go_r       <= 1'b0;
            periodic_r <= 1'b0;
            ie_r       <= 1'b0;
            expired_r  <= 1'b0;
        end else begin
            cnt_r <= cnt_next_s;
            // a CTRL write in the expiry cycle overrides the one-shot go clear
            if (ctrl_wr_s) begin
                go_r       <= bus.wr_data[CTRL_GO];
                periodic_r <= bus.wr_data[CTRL_PERIODIC];
                ie_r       <= bus.wr_data[CTRL_IE];
            end else if (hit_s && !periodic_r) begin
                go_r <= 1'b0;
            end
            if (hit_s) begin
                expired_r <= 1'b1;
            end else if (w1c_s) begin
                expired_r <= 1'b0;
            end
            if (rd_lo_s) begin
                shadow_r <= cnt_r[CNT_W-1:32];
            end
        end
    end

    // Compare register, written in two halves
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmp_r <= {CNT_W{1'b0}};
        end else begin
            if (wr_s && (bus.addr == REG_CMP_LO)) begin
                cmp_r[31:0] <= bus.wr_data;
            end
            if (wr_s && (bus.addr == REG_CMP_HI)) begin
                cmp_r[CNT_W-1:32] <= bus.wr_data[HI_W-1:0];
            end
        end
    end

    // Combinational read mux; idle slot drives zero
    always_comb begin
        rd_mux_s = 32'd0;
        if (bus.cs) begin
            case (bus.addr)
                REG_CNT_LO: rd_mux_s = cnt_r[31:0];
                REG_CNT_HI: rd_mux_s = 32'(shadow_r);
                REG_CTRL:   rd_mux_s = ctrl_word(go_r, periodic_r, ie_r);
                REG_CMP_LO: rd_mux_s = cmp_r[31:0];
                REG_CMP_HI: rd_mux_s = 32'(cmp_r[CNT_W-1:32]);
                REG_STATUS: rd_mux_s = {31'd0, expired_r};
                default:    rd_mux_s = 32'd0;
            endcase
        end else begin
            rd_mux_s = 32'd0;
        end
    end

    assign bus.rd_data = rd_mux_s;
    assign irq         = expired_r & ie_r;

endmodule

// File: tb/tb_fpro_timer_core.sv
// Self-checking bench for fpro_timer_core: directed scenarios plus randomized bus
// traffic, all compared every cycle against a behavioural register-level model.
module tb_fpro_timer_core;
    import fpro_timer_pkg::*;

    localparam int CNT_W = 48;
    localparam logic [63:0] MASK = (64'd1 << CNT_W) - 64'd1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic irq;

    fpro_timer_if bus ();

    fpro_timer_core #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // behavioural model of the programmer-visible state
    logic [63:0] m_cnt    = 64'd0;
    logic [63:0] m_cmp    = 64'd0;
    logic [63:0] m_shadow = 64'd0;
    logic        m_go     = 1'b0;
    logic        m_per    = 1'b0;
    logic        m_ie     = 1'b0;
    logic        m_exp    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            REG_CNT_LO: return m_cnt[31:0];
            REG_CNT_HI: return m_shadow[31:0];
            REG_CTRL:   return {28'd0, m_ie, m_per, 1'b0, m_go};
            REG_CMP_LO: return m_cmp[31:0];
            REG_CMP_HI: return m_cmp[63:32];
            REG_STATUS: return {31'd0, m_exp};
            default:    return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic        wr;
        logic        ctrl_wr;
        logic        hit;
        logic [31:0] wd;
        logic [63:0] n_cnt;
        wr      = bus.cs && bus.write;
        wd      = bus.wr_data;
        ctrl_wr = wr && (bus.addr == REG_CTRL);
        hit     = m_go && (m_cmp != 64'd0) && (m_cnt == m_cmp);
        if (ctrl_wr && wd[1])  n_cnt = 64'd0;
        else if (hit)          n_cnt = m_per ? 64'd0 : m_cnt;
        else if (m_go)         n_cnt = (m_cnt + 64'd1) & MASK;
        else                   n_cnt = m_cnt;
        if (bus.cs && bus.read && (bus.addr == REG_CNT_LO)) m_shadow = m_cnt >> 32;
        if (hit) m_exp = 1'b1;
        else if (wr && (bus.addr == REG_STATUS) && wd[0]) m_exp = 1'b0;
        if (ctrl_wr) begin
            m_go  = wd[0];
            m_per = wd[2];
            m_ie  = wd[3];
        end else if (hit && !m_per) begin
            m_go = 1'b0;
        end
        if (wr && (bus.addr == REG_CMP_LO)) m_cmp = {m_cmp[63:32], wd};
        if (wr && (bus.addr == REG_CMP_HI)) m_cmp = (({32'd0, wd} << 32) | {32'd0, m_cmp[31:0]}) & MASK;
        m_cnt = n_cnt;
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_cnt = 64'd0; m_cmp = 64'd0; m_shadow = 64'd0;
            m_go = 1'b0; m_per = 1'b0; m_ie = 1'b0; m_exp = 1'b0;
        end else begin
            model_step();
        end
    end

    // every-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            check("irq_model", 64'(irq), 64'(m_exp & m_ie));
            if (!bus.cs)
                check("rd_idle_zero", 64'(bus.rd_data), 64'd0);
            else if (bus.read)
                check("rd_model", 64'(bus.rd_data), 64'(model_read(bus.addr)));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic c, input logic r, input logic w, input logic [4:0] a, input logic [31:0] d);
        @(posedge clk);
        #2;
        bus.cs = c; bus.read = r; bus.write = w; bus.addr = a; bus.wr_data = d;
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
        drive(1'b1, 1'b0, 1'b1, a, d);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
        drive(1'b1, 1'b1, 1'b0, a, 32'd0);
        @(negedge clk);
        check(name, 64'(bus.rd_data), 64'(exp));
    endtask

    logic        r_cs, r_rd, r_wr;
    logic [4:0]  r_a;
    logic [31:0] r_d;
    int          sel;

    initial begin
        bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0; bus.addr = 5'd0; bus.wr_data = 32'd0;
        #1;
        check("reset_rd_cs_low", 64'(bus.rd_data), 64'd0);
        check("reset_irq", 64'(irq), 64'd0);
        bus.cs = 1'b1; bus.read = 1'b1; bus.addr = REG_CNT_LO;
        #1;
        check("reset_cnt_lo", 64'(bus.rd_data), 64'd0);
        bus.cs = 1'b0; bus.read = 1'b0;
        @(posedge clk); #4; reset = 1'b0;
        rd_chk("post_reset_ctrl", REG_CTRL, 32'd0);
        rd_chk("post_reset_cmp_lo", REG_CMP_LO, 32'd0);
        rd_chk("post_reset_status", REG_STATUS, 32'd0);

        // periodic, compare 5 -> period 6
        wr_reg(REG_CMP_LO, 32'd5);
        wr_reg(REG_CTRL, 32'b0101);
        for (int k = 0; k < 6; k++) rd_chk("periodic_count", REG_CNT_LO, 32'(k));
        rd_chk("periodic_expired", REG_STATUS, 32'd1);
        rd_chk("periodic_restart", REG_CNT_LO, 32'd1);
        wr_reg(REG_STATUS, 32'd1);
        wr_reg(REG_CTRL, 32'd0);

        // one-shot with interrupt, compare 3
        wr_reg(REG_CTRL, 32'b0010);
        wr_reg(REG_CMP_LO, 32'd3);
        wr_reg(REG_CTRL, 32'b1001);
        repeat (3) idle();
        idle(); @(negedge clk); check("oneshot_irq_before", 64'(irq), 64'd0);
        idle(); @(negedge clk); check("oneshot_irq_set", 64'(irq), 64'd1);
        rd_chk("oneshot_go_cleared", REG_CTRL, 32'd8);
        rd_chk("oneshot_cnt_hold", REG_CNT_LO, 32'd3);
        wr_reg(REG_STATUS, 32'd1); @(negedge clk); check("irq_until_w1c", 64'(irq), 64'd1);
        idle(); @(negedge clk); check("irq_after_w1c", 64'(irq), 64'd0);
        wr_reg(REG_CTRL, 32'd0);

        // shadow: low word all ones, high word 0 at latch time
        idle();
        @(negedge clk);
        force dut.cnt_r = 48'h0000_FFFF_FFFF;
        m_cnt = 64'h0000_FFFF_FFFF;
        @(negedge clk);
        release dut.cnt_r;
        rd_chk("shadow_cnt_lo", REG_CNT_LO, 32'hFFFF_FFFF);
        wr_reg(REG_CTRL, 32'd1);
        wr_reg(REG_CTRL, 32'd0);
        rd_chk("shadow_stale_hi", REG_CNT_HI, 32'd0);
        rd_chk("carry_lo", REG_CNT_LO, 32'd0);
        rd_chk("shadow_new_hi", REG_CNT_HI, 32'd1);

        // full-width wrap with compare 0
        wr_reg(REG_CMP_LO, 32'd0);
        idle();
        @(negedge clk);
        force dut.cnt_r = 48'hFFFF_FFFF_FFFE;
        m_cnt = 64'h0000_FFFF_FFFF_FFFE;
        @(negedge clk);
        release dut.cnt_r;
        wr_reg(REG_CTRL, 32'd1);
        rd_chk("wrap_m2", REG_CNT_LO, 32'hFFFF_FFFE);
        rd_chk("wrap_m1", REG_CNT_LO, 32'hFFFF_FFFF);
        rd_chk("wrap_zero", REG_CNT_LO, 32'd0);
        rd_chk("wrap_hi_zero", REG_CNT_HI, 32'd0);
        rd_chk("wrap_no_expire", REG_STATUS, 32'd0);
        wr_reg(REG_CTRL, 32'd0);

        // expiry coincident with W1C, then clear+go
        wr_reg(REG_CTRL, 32'b0010);
        wr_reg(REG_CMP_LO, 32'd2);
        wr_reg(REG_CTRL, 32'b0001);
        idle();
        idle();
        wr_reg(REG_STATUS, 32'd1);
        rd_chk("set_wins_w1c", REG_STATUS, 32'd1);
        wr_reg(REG_CTRL, 32'b0011);
        rd_chk("clear_with_go", REG_CNT_LO, 32'd0);
        rd_chk("clear_then_count", REG_CNT_LO, 32'd1);
        wr_reg(REG_STATUS, 32'd1);
        wr_reg(REG_CTRL, 32'd0);

        // randomized traffic checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            r_cs = ($urandom_range(0, 7) != 0);
            r_rd = 1'($urandom_range(0, 1));
            r_wr = ($urandom_range(0, 2) == 0);
            sel  = $urandom_range(0, 9);
            r_a  = (sel < 8) ? 5'(sel % 6) : 5'($urandom_range(6, 31));
            case (r_a)
                REG_CTRL: begin
                    r_d = $urandom & 32'hFFFF_FFFD;
                    if ($urandom_range(0, 7) == 0) r_d = r_d | 32'd2;
                end
                REG_CMP_LO: r_d = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 12));
                REG_CMP_HI: r_d = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'd0;
                default:    r_d = 32'($urandom);
            endcase
            drive(r_cs, r_rd, r_wr, r_a, r_d);
        end

        // asynchronous reset while running periodic with irq high
        wr_reg(REG_STATUS, 32'd1);
        wr_reg(REG_CMP_HI, 32'd0);
        wr_reg(REG_CTRL, 32'b0010);
        wr_reg(REG_CMP_LO, 32'd4);
        wr_reg(REG_CTRL, 32'b1101);
        repeat (7) idle();
        @(negedge clk);
        check("pre_reset_irq", 64'(irq), 64'd1);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("async_reset_irq", 64'(irq), 64'd0);
        bus.cs = 1'b1; bus.read = 1'b0; bus.write = 1'b0;
        for (int a = 0; a < 6; a++) begin
            bus.addr = 5'(a);
            #1;
            check("async_reset_regs", 64'(bus.rd_data), 64'd0);
        end
        @(posedge clk); #4;
        reset = 1'b0;
        repeat (10) idle();
        rd_chk("after_reset_cnt", REG_CNT_LO, 32'd0);
        rd_chk("after_reset_status", REG_STATUS, 32'd0);
        rd_chk("after_reset_ctrl", REG_CTRL, 32'd0);
        idle();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
